parallel_to_serial: RTL

PARALLEL_TO_SERIAL -- requirements
Module: parallel_to_serial

---
 rtl/parallel_to_serial_pkg.sv | 14 +
 rtl/sync_fifo.sv | 63 ++++++
 rtl/parallel_to_serial.sv | 121 ++++++++++++
 3 files changed

// File: rtl/parallel_to_serial_pkg.sv
// Shared definitions for the parallel-to-serial transmitter and its buffer.
package parallel_to_serial_pkg;

    // Default word width and buffer depth
    localparam int unsigned WIDTH_DEFAULT = 4;
    localparam int unsigned DEPTH_DEFAULT = 4;

    // Transmitter FSM encoding
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy and show-ahead read data.
// A push into a full buffer is refused even when a pop happens on the same edge.
module sync_fifo
    import parallel_to_serial_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally at DEPTH (power of two); level saturates by construction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage array carries no reset; validity is tracked by pointers and level
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/parallel_to_serial.sv
// Buffered parallel-to-serial transmitter: MSB first, back-to-back words with
// no idle gap, all serial-side outputs registered.
module parallel_to_serial
    import parallel_to_serial_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     serial_out,
    output logic                     frame_start,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] head;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_next;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic             load;
    logic             serial_next;
    logic             frame_next;
    logic             busy_next;

    // Ready depends only on the registered occupancy, never on in_valid
    assign in_ready = !full;
    assign push     = in_valid && in_ready;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    // Next-state, shift-register and output decode
    always_comb begin
        state_next  = state;
        sreg_next   = sreg;
        cnt_next    = cnt;
        load        = 1'b0;
        pop         = 1'b0;
        serial_next = 1'b0;
        frame_next  = 1'b0;
        busy_next   = 1'b0;
        shifted     = sreg << 1;

        case (state)
            IDLE: begin
                load = !empty;
            end
            SHIFT: begin
                if (cnt != '0) begin
                    sreg_next   = shifted;
                    cnt_next    = cnt - CW'(1);
                    serial_next = shifted[WIDTH-1];
                    busy_next   = 1'b1;
                end else if (!empty) begin
                    load = 1'b1;
                end else begin
                    state_next = IDLE;
                    sreg_next  = '0;
                end
            end
        endcase

        // Loading the next word doubles as the first bit of its frame
        if (load) begin
            pop         = 1'b1;
            state_next  = SHIFT;
            sreg_next   = head;
            cnt_next    = CW'(WIDTH - 1);
            serial_next = head[WIDTH-1];
            frame_next  = 1'b1;
            busy_next   = 1'b1;
        end
    end

    // State, shift register, bit counter and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            sreg        <= '0;
            cnt         <= '0;
            serial_out  <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            sreg        <= sreg_next;
            cnt         <= cnt_next;
            serial_out  <= serial_next;
            frame_start <= frame_next;
            busy        <= busy_next;
        end
    end

endmodule
